// File: rtl/serial_subtractor_if.sv
// Handshake/operand bundle for the bit-serial subtractor.
interface serial_subtractor_if #(
  parameter int N = 4
);
  logic         start;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic [N-1:0] D;
  logic         bout;
  logic         busy;
  logic         done;

  modport master (output start, A, B, input D, bout, busy, done);
  modport slave  (input start, A, B, output D, bout, busy, done);
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial N-bit unsigned subtractor, D = A - B, LSB first.
// Each RUN cycle chains two half-subtractor stages (operand bits, then the
// stored borrow) into one full-subtractor step; a single flop carries borrow.
module serial_subtractor #(
  parameter int N = 4
) (
  input logic               clk,
  input logic               rst,
  serial_subtractor_if.slave bus
);
  localparam int CW = (N > 2) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  logic [N-1:0]  sa;
  logic [N-1:0]  sb;
  logic [N-1:0]  r;
  logic          br;
  logic [CW-1:0] cnt;

  logic a0, b0, h, p, d, q, br_nxt;
  logic [N-1:0] r_nxt;

  // One full-subtractor step on the current operand LSBs and stored borrow.
  always_comb begin
    a0     = sa[0];
    b0     = sb[0];
    h      = a0 ^ b0;
    p      = ~a0 & b0;
    d      = h ^ br;
    q      = ~h & br;
    br_nxt = p | q;
    r_nxt  = {d, r[N-1:1]};
  end

  // Control FSM plus datapath; every output is registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      sa       <= '0;
      sb       <= '0;
      r        <= '0;
      br       <= 1'b0;
      cnt      <= '0;
      bus.D    <= '0;
      bus.bout <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            sa       <= bus.A;
            sb       <= bus.B;
            br       <= 1'b0;
            cnt      <= '0;
            bus.busy <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          br  <= br_nxt;
          r   <= r_nxt;
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          cnt <= cnt + 1'b1;
          // Last bit: publish the word the same edge the final bit is formed.
          if (cnt == CW'(N - 1)) begin
            bus.D    <= r_nxt;
            bus.bout <= br_nxt;
            bus.done <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor at N=4 and N=8.
module tb_serial_subtractor;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  serial_subtractor_if #(.N(4)) if4 ();
  serial_subtractor_if #(.N(8)) if8 ();

  serial_subtractor #(.N(4)) dut4 (.clk(clk), .rst(rst), .bus(if4));
  serial_subtractor #(.N(8)) dut8 (.clk(clk), .rst(rst), .bus(if8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one N=4 operation and wait for its done pulse. edges counts clock
  // edges from the one sampling start up to the one raising done, inclusive.
  task automatic run_op(input logic [3:0] a, input logic [3:0] b,
                        output int edges, output int busy_cnt,
                        output logic [3:0] dv, output logic bo,
                        output logic tmo, output logic done_after);
    if4.A = a; if4.B = b; if4.start = 1'b1;
    step();
    if4.start = 1'b0;
    edges = 1; busy_cnt = int'(if4.busy); tmo = 1'b0;
    while (!if4.done) begin
      if (edges >= 40) begin tmo = 1'b1; break; end
      step();
      edges++;
      busy_cnt += int'(if4.busy);
    end
    dv = if4.D; bo = if4.bout;
    step();
    done_after = if4.done;
  endtask

  task automatic test_reset();
    rst = 1'b1; if4.start = 1'b0; if8.start = 1'b0;
    if4.A = '0; if4.B = '0; if8.A = '0; if8.B = '0;
    step(); step();
    rst = 1'b0;
    checks++;
    if ({if4.D, if4.bout, if4.busy, if4.done} !== 7'b0) begin
      errors++; $display("FAIL reset4: got D=%h bout=%b busy=%b done=%b, want all 0",
                         if4.D, if4.bout, if4.busy, if4.done);
    end
    checks++;
    if ({if8.D, if8.bout, if8.busy, if8.done} !== 11'b0) begin
      errors++; $display("FAIL reset8: got D=%h bout=%b busy=%b done=%b, want all 0",
                         if8.D, if8.bout, if8.busy, if8.done);
    end
  endtask

  task automatic test_basic();
    int e, bc; logic [3:0] dv; logic bo, tmo, da;
    run_op(4'd9, 4'd5, e, bc, dv, bo, tmo, da);
    checks++;
    if (tmo !== 1'b0 || e !== 5) begin
      errors++; $display("FAIL basic_latency: got edges=%0d tmo=%b, want 5 0", e, tmo);
    end
    checks++;
    if (dv !== 4'b0100 || bo !== 1'b0) begin
      errors++; $display("FAIL basic_result: got D=%b bout=%b, want 0100 0", dv, bo);
    end
    checks++;
    if (bc !== 5) begin
      errors++; $display("FAIL basic_busy: got busy cycles=%0d, want 5", bc);
    end
    checks++;
    if (da !== 1'b0 || if4.busy !== 1'b0) begin
      errors++; $display("FAIL basic_done_pulse: got done=%b busy=%b after, want 0 0", da, if4.busy);
    end
  endtask

  task automatic test_vectors();
    logic [3:0] va [3] = '{4'd3, 4'd0, 4'd10};
    logic [3:0] vb [3] = '{4'd7, 4'd1, 4'd10};
    logic [3:0] vd [3] = '{4'd12, 4'd15, 4'd0};
    logic       vo [3] = '{1'b1, 1'b1, 1'b0};
    int e, bc; logic [3:0] dv; logic bo, tmo, da;
    for (int i = 0; i < 3; i++) begin
      run_op(va[i], vb[i], e, bc, dv, bo, tmo, da);
      checks++;
      if (dv !== vd[i] || bo !== vo[i] || tmo !== 1'b0) begin
        errors++; $display("FAIL vector%0d: got D=%0d bout=%b tmo=%b, want D=%0d bout=%b 0",
                           i, dv, bo, tmo, vd[i], vo[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int e, bc; logic [3:0] dv, ed; logic bo, tmo, da, eo;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        run_op(4'(a), 4'(b), e, bc, dv, bo, tmo, da);
        ed = 4'(a - b);
        eo = (a < b);
        checks++;
        if (dv !== ed || bo !== eo) begin
          errors++; $display("FAIL sweep %0d-%0d: got D=%0d bout=%b, want D=%0d bout=%b",
                             a, b, dv, bo, ed, eo);
        end
        checks++;
        if (tmo !== 1'b0 || e !== 5 || da !== 1'b0) begin
          errors++; $display("FAIL sweep_timing %0d-%0d: got edges=%0d tmo=%b done_after=%b, want 5 0 0",
                             a, b, e, tmo, da);
        end
      end
    end
  endtask

  task automatic test_start_ignored();
    int extra;
    if4.A = 4'd12; if4.B = 4'd3; if4.start = 1'b1;
    step();                                  // start sampled, RUN cycle 1
    if4.start = 1'b0;
    step();                                  // RUN cycle 2
    if4.A = 4'd1; if4.B = 4'd2; if4.start = 1'b1;
    step();
    if4.start = 1'b0;
    step(); step();                          // fifth edge: DONE
    checks++;
    if (if4.done !== 1'b1 || if4.D !== 4'd9 || if4.bout !== 1'b0) begin
      errors++; $display("FAIL ignore_result: got done=%b D=%0d bout=%b, want 1 9 0",
                         if4.done, if4.D, if4.bout);
    end
    if4.start = 1'b1;                        // pulse during the DONE cycle
    step();
    if4.start = 1'b0;
    extra = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      extra += int'(if4.done) + int'(if4.busy);
    end
    checks++;
    if (extra !== 0 || if4.D !== 4'd9) begin
      errors++; $display("FAIL ignore_no_second: got done/busy samples=%0d D=%0d, want 0 9",
                         extra, if4.D);
    end
  endtask

  task automatic test_reset_mid_run();
    int e, bc, seen; logic [3:0] dv; logic bo, tmo, da;
    run_op(4'd6, 4'd2, e, bc, dv, bo, tmo, da);
    checks++;
    if (dv !== 4'd4 || bo !== 1'b0 || tmo !== 1'b0) begin
      errors++; $display("FAIL pre_abort: got D=%0d bout=%b tmo=%b, want 4 0 0", dv, bo, tmo);
    end
    if4.A = 4'd5; if4.B = 4'd9; if4.start = 1'b1;
    step();
    if4.start = 1'b0;
    step(); step();                          // now in RUN cycle 3
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if ({if4.D, if4.bout, if4.busy, if4.done} !== 7'b0) begin
      errors++; $display("FAIL abort_clear: got D=%0d bout=%b busy=%b done=%b, want all 0",
                         if4.D, if4.bout, if4.busy, if4.done);
    end
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      seen += int'(if4.done);
    end
    checks++;
    if (seen !== 0) begin
      errors++; $display("FAIL abort_no_done: got %0d done pulses, want 0", seen);
    end
    run_op(4'd8, 4'd1, e, bc, dv, bo, tmo, da);
    checks++;
    if (dv !== 4'd7 || bo !== 1'b0 || tmo !== 1'b0) begin
      errors++; $display("FAIL post_abort: got D=%0d bout=%b tmo=%b, want 7 0 0", dv, bo, tmo);
    end
  endtask

  task automatic test_wide();
    int e; logic tmo;
    if8.A = 8'h00; if8.B = 8'hFF; if8.start = 1'b1;
    step();
    if8.start = 1'b0;
    e = 1; tmo = 1'b0;
    while (!if8.done) begin
      if (e >= 60) begin tmo = 1'b1; break; end
      step();
      e++;
    end
    checks++;
    if (tmo !== 1'b0 || e !== 9) begin
      errors++; $display("FAIL wide_latency: got edges=%0d tmo=%b, want 9 0", e, tmo);
    end
    checks++;
    if (if8.D !== 8'h01 || if8.bout !== 1'b1) begin
      errors++; $display("FAIL wide_result: got D=%h bout=%b, want 01 1", if8.D, if8.bout);
    end
    if8.A = 8'h55; if8.B = 8'h11;            // inputs move, no start
    for (int i = 0; i < 20; i++) begin
      step();
      checks++;
      if (if8.D !== 8'h01 || if8.bout !== 1'b1 || if8.done !== 1'b0) begin
        errors++; $display("FAIL wide_hold%0d: got D=%h bout=%b done=%b, want 01 1 0",
                           i, if8.D, if8.bout, if8.done);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    test_reset();
    test_basic();
    test_vectors();
    test_back_to_back();
    test_start_ignored();
    test_reset_mid_run();
    test_wide();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
